if_stage_buf: RTL and testbench

IF_STAGE_BUF -- requirements
Module: if_stage_buf

---
 rtl/if_stage_buf.sv | 140 ++++++++++++++
 tb/tb_if_stage_buf.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage_buf.sv
// Fetch stage with an in-order instruction buffer; a redirect cancels in-flight reads. data_ok to ID-visible: 1 cycle.
// Requests stall once outstanding+buffered reaches IBUF_DEPTH. Define IF_PERF_CNT_EN for pop/drop counters.
module if_stage_buf #(
  parameter logic [31:0] RESET_PC   = 32'h1c000000,
  parameter int          IBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        id_allowin,
  input  logic [32:0] br_bus,
  input  logic        flush,
  input  logic [31:0] excep_entry,
  output logic        if_to_id_valid,
  output logic [64:0] if_to_id_bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_cancel_cnt
`endif
);
  localparam int AW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(IBUF_DEPTH);
  localparam logic [CW-1:0] FULL_C  = CW'(IBUF_DEPTH);

  logic [31:0]   fetch_pc;
  logic          halt;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] cancel_cnt;
  logic [CW-1:0] buf_cnt;
  logic [AW-1:0] buf_wr;
  logic [AW-1:0] buf_rd;
  logic [AW-1:0] pcq_wr;
  logic [AW-1:0] pcq_rd;
  logic [64:0]   buf_mem [IBUF_DEPTH];
  logic [31:0]   pcq_mem [IBUF_DEPTH];

  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          adef;
  logic [CW:0]   in_use;
  logic          fire;
  logic          drop;
  logic          rsp_push;
  logic          adef_push;
  logic          push;
  logic          pop;
  logic [64:0]   push_dat;
  logic [CW-1:0] outstanding_nxt;

  assign redirect    = flush | br_bus[32];
  assign redirect_pc = flush ? excep_entry : br_bus[31:0];
  assign adef        = fetch_pc[1:0] != 2'b00;
  assign in_use      = {1'b0, outstanding} + {1'b0, buf_cnt};

  // Cancelled reads still occupy a slot until their response returns.
  assign inst_sram_req  = resetn & ~redirect & ~halt & ~adef & (in_use < DEPTH_W);
  assign inst_sram_wr   = 1'b0;
  assign inst_sram_size = 2'b10;
  assign inst_sram_addr = fetch_pc;

  assign fire      = inst_sram_req & inst_sram_addr_ok;
  assign drop      = inst_sram_data_ok & (cancel_cnt != '0);
  assign rsp_push  = inst_sram_data_ok & ~drop;
  // The fault entry waits for every live response so it lands after them in order.
  assign adef_push = ~redirect & ~halt & adef & (outstanding == cancel_cnt) & (buf_cnt != FULL_C);
  assign push      = rsp_push | adef_push;
  assign push_dat  = adef_push ? {32'h0, fetch_pc, 1'b1}
                               : {inst_sram_rdata, pcq_mem[pcq_rd], 1'b0};

  assign if_to_id_valid  = buf_cnt != '0;
  assign if_to_id_bus    = buf_mem[buf_rd];
  assign pop             = if_to_id_valid & id_allowin;
  assign outstanding_nxt = outstanding + CW'(fire) - CW'(inst_sram_data_ok);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc    <= RESET_PC;
      halt        <= 1'b0;
      outstanding <= '0;
      cancel_cnt  <= '0;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (fire)              pcq_wr <= pcq_wr + AW'(1);
      if (inst_sram_data_ok) pcq_rd <= pcq_rd + AW'(1);
      if (redirect) begin
        fetch_pc   <= redirect_pc;
        halt       <= 1'b0;
        cancel_cnt <= outstanding_nxt;
      end else begin
        if (fire)      fetch_pc   <= fetch_pc + 32'd4;
        if (adef_push) halt       <= 1'b1;
        if (drop)      cancel_cnt <= cancel_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_cnt <= '0;
      buf_wr  <= '0;
      buf_rd  <= '0;
    end else if (redirect) begin
      buf_cnt <= '0;
      buf_wr  <= '0;
      buf_rd  <= '0;
    end else begin
      buf_cnt <= buf_cnt + CW'(push) - CW'(pop);
      if (push) buf_wr <= buf_wr + AW'(1);
      if (pop)  buf_rd <= buf_rd + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) buf_mem[buf_wr] <= push_dat;
    if (fire) pcq_mem[pcq_wr] <= fetch_pc;
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_fetch_cnt  <= 32'd0;
      perf_cancel_cnt <= 32'd0;
    end else begin
      if (pop)  perf_fetch_cnt  <= perf_fetch_cnt + 32'd1;
      if (drop) perf_cancel_cnt <= perf_cancel_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage_buf.sv
// Bench for if_stage_buf: latency-programmable memory model plus an ideal fetch-stream reference.
module tb_if_stage_buf;
  localparam logic [31:0] RST_PC = 32'h1c000000;
  localparam int          DEPTH  = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok = 1'b0;
  logic        inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata   = 32'h0;
  logic        id_allowin, flush;
  logic [32:0] br_bus;
  logic [31:0] excep_entry;
  logic        if_to_id_valid;
  logic [64:0] if_to_id_bus;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_cancel_cnt;
`endif

  int          n_checks, n_fail;
  int unsigned cyc = 0;
  int          mem_lat = 1, stall_pct = 0, acc_cnt = 0, acc_limit = 1 << 30;
  logic [31:0] salt;

  typedef struct packed { logic [31:0] addr; logic [31:0] due; } mreq_t;
  typedef struct packed {
    logic is_pop; logic [64:0] bus; logic fl; logic [32:0] br; logic [31:0] ex; logic [31:0] cyc;
  } ev_t;
  mreq_t mq[$];
  ev_t   evq[$];

  if_stage_buf #(.RESET_PC(RST_PC), .IBUF_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata), .id_allowin(id_allowin), .br_bus(br_bus),
    .flush(flush), .excep_entry(excep_entry),
    .if_to_id_valid(if_to_id_valid), .if_to_id_bus(if_to_id_bus)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_cancel_cnt(perf_cancel_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ salt;
  endfunction

  // Ideal fetch stream: word at pc, or the fault marker for a misaligned pc.
  function automatic logic [64:0] model_entry(input logic [31:0] pc);
    if (pc[1:0] != 2'b00) return {32'h0, pc, 1'b1};
    return {mem_word(pc), pc, 1'b0};
  endfunction

  // In-order memory: fixed latency per test, random address stalls, optional accept cap.
  always @(negedge clk) begin
    if (!resetn) begin
      mq.delete();
      acc_cnt = 0;
      inst_sram_addr_ok = 1'b0;
      inst_sram_data_ok = 1'b0;
    end else begin
      inst_sram_data_ok = 1'b0;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = mem_word(mq[0].addr);
        void'(mq.pop_front());
      end
      inst_sram_addr_ok = (acc_cnt < acc_limit) && ($urandom_range(0, 99) >= stall_pct);
      if (inst_sram_req && inst_sram_addr_ok) begin
        mq.push_back('{addr: inst_sram_addr, due: 32'(cyc + mem_lat)});
        acc_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      if (if_to_id_valid && id_allowin)
        evq.push_back('{is_pop: 1'b1, bus: if_to_id_bus, fl: 1'b0, br: 33'h0, ex: 32'h0, cyc: cyc});
      if (flush || br_bus[32])
        evq.push_back('{is_pop: 1'b0, bus: 65'h0, fl: flush, br: br_bus, ex: excep_entry, cyc: cyc});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick(1);
    resetn = 1'b0; id_allowin = 1'b0; flush = 1'b0; br_bus = '0; excep_entry = '0;
    tick(3);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    tick(1);
    resetn = 1'b0; id_allowin = 1'b1; flush = 1'b0; br_bus = '0; excep_entry = '0;
    #2;
    n_checks++; if (inst_sram_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", inst_sram_req); end
    n_checks++; if (if_to_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", if_to_id_valid); end
    n_checks++; if (inst_sram_addr !== RST_PC) begin n_fail++; $display("FAIL reset_addr: got %h want %h", inst_sram_addr, RST_PC); end
    n_checks++; if ({inst_sram_wr, inst_sram_size} !== 3'b010) begin n_fail++; $display("FAIL reset_wr_size: got %b want 010", {inst_sram_wr, inst_sram_size}); end
`ifdef IF_PERF_CNT_EN
    n_checks++; if ({perf_fetch_cnt, perf_cancel_cnt} !== 64'h0) begin n_fail++; $display("FAIL reset_perf: got %h want 0", {perf_fetch_cnt, perf_cancel_cnt}); end
`endif
    tick(2);
    n_checks++; if (inst_sram_req !== 1'b0) begin n_fail++; $display("FAIL reset_req_held: got %b want 0", inst_sram_req); end
    resetn = 1'b1;
    #1;
    n_checks++; if (inst_sram_req !== 1'b1) begin n_fail++; $display("FAIL reset_first_req: got %b want 1", inst_sram_req); end
    n_checks++; if (inst_sram_addr !== RST_PC) begin n_fail++; $display("FAIL reset_first_addr: got %h want %h", inst_sram_addr, RST_PC); end
  endtask

  task automatic test_stream();
    int base, npop; int unsigned rel; logic [31:0] exp_pc;
    mem_lat = 1; stall_pct = 0; acc_limit = 1 << 30;
    do_reset();
    base = evq.size(); rel = cyc; id_allowin = 1'b1;
    tick(6);
    n_checks++;
    if (evq.size() < base + 3) begin n_fail++; $display("FAIL stream_count: got %0d want >=3", evq.size() - base); end
    else for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (evq[base+i].bus !== model_entry(RST_PC + 32'(4*i))) begin
        n_fail++; $display("FAIL stream_entry%0d: got %h want %h", i, evq[base+i].bus, model_entry(RST_PC + 32'(4*i))); end
      n_checks++;
      if (evq[base+i].cyc !== 32'(rel + 2 + i)) begin
        n_fail++; $display("FAIL stream_timing%0d: got cycle %0d want %0d", i, evq[base+i].cyc, rel + 2 + i); end
    end
    stall_pct = 30;
    repeat (300) begin tick(1); id_allowin = ($urandom_range(0, 1) == 1); end
    id_allowin = 1'b1; stall_pct = 0;
    tick(20);
    exp_pc = RST_PC; npop = 0;
    for (int i = base; i < evq.size(); i++) begin
      n_checks++; npop++;
      if (evq[i].bus !== model_entry(exp_pc)) begin
        n_fail++; $display("FAIL stream_rand: got %h want %h", evq[i].bus, model_entry(exp_pc)); end
      exp_pc += 4;
    end
    n_checks++; if (npop < 100) begin n_fail++; $display("FAIL stream_progress: got %0d pops want >=100", npop); end
`ifdef IF_PERF_CNT_EN
    n_checks++; if (perf_fetch_cnt !== 32'(npop)) begin n_fail++; $display("FAIL perf_fetch: got %0d want %0d", perf_fetch_cnt, npop); end
`endif
  endtask

  task automatic test_backpressure();
    int base; logic [31:0] exp_pc;
    mem_lat = 1; stall_pct = 0; acc_limit = 1 << 30;
    do_reset();
    base = evq.size();
    tick(10);
    n_checks++; if (inst_sram_req !== 1'b0) begin n_fail++; $display("FAIL bp_req: got %b want 0", inst_sram_req); end
    n_checks++; if (acc_cnt != DEPTH || mq.size() != 0) begin n_fail++; $display("FAIL bp_fill: got %0d accepted %0d pending want %0d/0", acc_cnt, mq.size(), DEPTH); end
    n_checks++; if (evq.size() != base || if_to_id_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold: got %0d pops valid %b want 0 pops valid 1", evq.size() - base, if_to_id_valid); end
    id_allowin = 1'b1;
    tick(12);
    exp_pc = RST_PC;
    for (int i = base; i < evq.size(); i++) begin
      n_checks++;
      if (evq[i].bus !== model_entry(exp_pc)) begin n_fail++; $display("FAIL bp_resume: got %h want %h", evq[i].bus, model_entry(exp_pc)); end
      exp_pc += 4;
    end
    n_checks++; if (evq.size() - base < DEPTH + 4) begin n_fail++; $display("FAIL bp_drain: got %0d pops want >=%0d", evq.size() - base, DEPTH + 4); end
  endtask

  task automatic test_branch_cancel();
    int base, k, idx; bit seen;
    mem_lat = 8; stall_pct = 0; acc_limit = 3;
    do_reset();
    base = evq.size(); id_allowin = 1'b1; k = 0;
    while (acc_cnt < 3 && k < 20) begin tick(1); k++; end
    n_checks++; if (acc_cnt != 3) begin n_fail++; $display("FAIL br_setup: got %0d accepted want 3", acc_cnt); end
    br_bus = {1'b1, 32'h1c000100}; acc_limit = 1 << 30;
    tick(1);
    br_bus = '0;
    tick(30);
    idx = -1; seen = 0;
    for (int i = base; i < evq.size(); i++) begin
      if (!evq[i].is_pop) seen = 1;
      else if (!seen) begin n_checks++; n_fail++; $display("FAIL br_stale_pop: got %h want none", evq[i].bus); end
      else if (idx < 0) idx = i;
    end
    n_checks++;
    if (idx < 0) begin n_fail++; $display("FAIL br_first: got no entry want pc 1c000100"); end
    else if (evq[idx].bus !== model_entry(32'h1c000100)) begin
      n_fail++; $display("FAIL br_first: got %h want %h", evq[idx].bus, model_entry(32'h1c000100)); end
`ifdef IF_PERF_CNT_EN
    n_checks++; if (perf_cancel_cnt !== 32'd3) begin n_fail++; $display("FAIL br_perf_cancel: got %0d want 3", perf_cancel_cnt); end
`endif
  endtask

  task automatic test_flush_priority();
    int base, idx; bit seen;
    mem_lat = 2; stall_pct = 0; acc_limit = 1 << 30;
    do_reset();
    id_allowin = 1'b1;
    tick(5);
    base = evq.size();
    flush = 1'b1; excep_entry = 32'h1c008000; br_bus = {1'b1, 32'h1c000200};
    tick(1);
    flush = 1'b0; br_bus = '0;
    tick(10);
    idx = -1; seen = 0;
    for (int i = base; i < evq.size(); i++) begin
      if (!evq[i].is_pop) seen = 1;
      else if (seen && idx < 0) idx = i;
    end
    n_checks++;
    if (idx < 0) begin n_fail++; $display("FAIL flush_prio: got no entry want pc 1c008000"); end
    else if (evq[idx].bus !== model_entry(32'h1c008000)) begin
      n_fail++; $display("FAIL flush_prio: got %h want %h", evq[idx].bus, model_entry(32'h1c008000)); end
  endtask

  task automatic test_adef();
    int base, nreq, npost, idx; bit seen;
    mem_lat = 1; stall_pct = 0; acc_limit = 1 << 30;
    do_reset();
    id_allowin = 1'b1;
    tick(4);
    base = evq.size();
    br_bus = {1'b1, 32'h1c000102};
    tick(1);
    br_bus = '0; nreq = 0;
    repeat (30) begin tick(1); if (inst_sram_req) nreq++; end
    n_checks++; if (nreq != 0) begin n_fail++; $display("FAIL adef_halt: got %0d req cycles want 0", nreq); end
    npost = 0; seen = 0;
    for (int i = base; i < evq.size(); i++) begin
      if (!evq[i].is_pop) seen = 1;
      else if (seen) begin
        npost++; n_checks++;
        if (evq[i].bus !== {32'h0, 32'h1c000102, 1'b1}) begin
          n_fail++; $display("FAIL adef_entry: got %h want %h", evq[i].bus, {32'h0, 32'h1c000102, 1'b1}); end
      end
    end
    n_checks++; if (npost != 1) begin n_fail++; $display("FAIL adef_count: got %0d entries want 1", npost); end
    base = evq.size();
    flush = 1'b1; excep_entry = RST_PC;
    tick(1);
    flush = 1'b0;
    tick(6);
    idx = -1; seen = 0;
    for (int i = base; i < evq.size(); i++) begin
      if (!evq[i].is_pop) seen = 1;
      else if (seen && idx < 0) idx = i;
    end
    n_checks++;
    if (idx < 0) begin n_fail++; $display("FAIL adef_resume: got no entry want pc %h", RST_PC); end
    else if (evq[idx].bus !== model_entry(RST_PC)) begin
      n_fail++; $display("FAIL adef_resume: got %h want %h", evq[idx].bus, model_entry(RST_PC)); end
  endtask

  task automatic test_redirect_random();
    int base, r; bit halted; logic [31:0] exp_pc;
    mem_lat = $urandom_range(1, 3); stall_pct = 25; acc_limit = 1 << 30;
    do_reset();
    base = evq.size();
    repeat (400) begin
      tick(1);
      id_allowin = ($urandom_range(0, 3) != 0); flush = 1'b0; br_bus = '0;
      excep_entry = RST_PC + ($urandom_range(0, 1023) << 2);
      r = $urandom_range(0, 99);
      if (r < 4)       flush = 1'b1;
      else if (r < 8)  br_bus = {1'b1, RST_PC + 32'($urandom_range(0, 1023) << 2)};
      else if (r < 9)  begin flush = 1'b1; br_bus = {1'b1, 32'h1c0ff000}; end
      else if (r < 10) br_bus = {1'b1, RST_PC + 32'($urandom_range(0, 1023) << 2) + 32'd1};
    end
    tick(1);
    flush = 1'b0; br_bus = '0; id_allowin = 1'b1; stall_pct = 0;
    tick(20);
    exp_pc = RST_PC; halted = 0;
    for (int i = base; i < evq.size(); i++) begin
      if (evq[i].is_pop) begin
        n_checks++;
        if (halted) begin n_fail++; $display("FAIL rand_after_adef: got %h want no entry", evq[i].bus); end
        else if (evq[i].bus !== model_entry(exp_pc)) begin
          n_fail++; $display("FAIL rand_stream: got %h want %h", evq[i].bus, model_entry(exp_pc)); end
        if (exp_pc[1:0] != 2'b00) halted = 1;
        else exp_pc += 4;
      end else begin
        exp_pc = evq[i].fl ? evq[i].ex : evq[i].br[31:0];
        halted = 0;
      end
    end
  endtask

  task automatic test_reset_midflight();
    int base; int unsigned rel;
    mem_lat = 3; stall_pct = 0; acc_limit = 1 << 30;
    do_reset();
    id_allowin = 1'b1;
    tick(5);
    resetn = 1'b0;
    #1;
    n_checks++; if (inst_sram_req !== 1'b0) begin n_fail++; $display("FAIL midrst_req: got %b want 0", inst_sram_req); end
    n_checks++; if (if_to_id_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", if_to_id_valid); end
    n_checks++; if (inst_sram_addr !== RST_PC) begin n_fail++; $display("FAIL midrst_addr: got %h want %h", inst_sram_addr, RST_PC); end
    tick(2);
    base = evq.size();
    resetn = 1'b1; rel = cyc;
    tick(8);
    n_checks++;
    if (evq.size() < base + 2) begin n_fail++; $display("FAIL midrst_refetch: got %0d entries want >=2", evq.size() - base); end
    else begin
      if (evq[base].bus !== model_entry(RST_PC) || evq[base].cyc !== 32'(rel + 4)) begin
        n_fail++; $display("FAIL midrst_refetch: got %h at %0d want %h at %0d", evq[base].bus, evq[base].cyc, model_entry(RST_PC), rel + 4); end
      n_checks++;
      if (evq[base+1].bus !== model_entry(RST_PC + 32'd4)) begin
        n_fail++; $display("FAIL midrst_second: got %h want %h", evq[base+1].bus, model_entry(RST_PC + 32'd4)); end
    end
  endtask

  initial begin
    salt = $urandom;
    n_checks = 0; n_fail = 0;
    resetn = 1'b0; id_allowin = 1'b0; flush = 1'b0; br_bus = '0; excep_entry = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_branch_cancel();
    test_flush_priority();
    test_adef();
    test_redirect_random();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
